// File: rtl/gray_pkg.sv
// Shared types and width-generic Gray helpers for the Gray codec pipeline.
package gray_pkg;

  // Helpers work on a fixed maximum width; callers zero-extend in and truncate out.
  localparam int unsigned GRAY_MAX_W = 64;
  localparam int unsigned GRAY_CNT_W = 7;

  typedef enum logic {GRAY_ENC = 1'b0, GRAY_DEC = 1'b1} gray_mode_e;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;
  typedef logic [GRAY_CNT_W-1:0] gray_cnt_t;

  // Binary to Gray; zero upper bits stay zero.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; zero upper bits contribute nothing to the prefix XOR.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits.
  function automatic gray_cnt_t popcount(input gray_word_t w);
    gray_cnt_t n;
    n = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      n = n + GRAY_CNT_W'(w[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// Tracks the last Gray-side word and counts transfers that jump more than one bit.
module gray_adj_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 SYS_CLK,
  input  logic                 reset,
  input  logic                 xfer,
  input  logic [WIDTH-1:0]     gw,
  input  logic                 clr_err,
  output logic                 adj_c,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] last_gw;
  logic             hist_valid;

  // Flag a transferring word whose distance from the previous one exceeds one bit.
  always_comb begin
    adj_c = 1'b0;
    if (xfer && hist_valid && !clr_err) begin
      adj_c = (popcount(GRAY_MAX_W'(gw ^ last_gw)) > GRAY_CNT_W'(1));
    end
  end

  // History update and saturating error count; a clear re-seeds from the same-cycle word.
  always_ff @(posedge SYS_CLK or negedge reset) begin
    if (!reset) begin
      last_gw    <= '0;
      hist_valid <= 1'b0;
      err_count  <= '0;
    end else begin
      if (clr_err) begin
        err_count <= '0;
      end else if (adj_c && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
      if (xfer) begin
        last_gw    <= gw;
        hist_valid <= 1'b1;
      end else if (clr_err) begin
        hist_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready binary<->Gray converter with adjacency checking.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 SYS_CLK,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_adj,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic             s1_valid;
  gray_mode_e       s1_mode;
  logic [WIDTH-1:0] s1_data;

  logic             adv1_c;
  logic             adv2_c;
  logic             xfer_c;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] gw_c;
  logic             adj_c;

  // Handshake advance terms and stage-1 conversion.
  always_comb begin
    adv2_c   = !out_valid || out_ready;
    adv1_c   = !s1_valid || adv2_c;
    in_ready = adv1_c;
    xfer_c   = s1_valid && adv2_c;
    if (s1_mode == GRAY_ENC) begin
      result_c = WIDTH'(bin2gray(GRAY_MAX_W'(s1_data)));
      gw_c     = result_c;
    end else begin
      result_c = WIDTH'(gray2bin(GRAY_MAX_W'(s1_data)));
      gw_c     = s1_data;
    end
  end

  // Stage 1: capture the accepted word and its mode.
  always_ff @(posedge SYS_CLK or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= GRAY_ENC;
      s1_data  <= '0;
    end else if (adv1_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= gray_mode_e'(in_mode);
        s1_data <= in_data;
      end
    end
  end

  // Stage 2: register the converted word and its adjacency flag.
  always_ff @(posedge SYS_CLK or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
      out_adj   <= 1'b0;
    end else if (adv2_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mode <= s1_mode;
        out_data <= result_c;
        out_adj  <= adj_c;
      end
    end
  end

  gray_adj_checker #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_adj (
    .SYS_CLK   (SYS_CLK),
    .reset     (reset),
    .xfer      (xfer_c),
    .gw        (gw_c),
    .clr_err   (clr_err),
    .adj_c     (adj_c),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Randomised scoreboard bench for gray_codec_pipe (WIDTH=4, 2-bit error counter).
module tb_gray_codec_pipe;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic          SYS_CLK = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_mode;
  logic [W-1:0]  out_data;
  logic          out_adj;
  logic          clr_err;
  logic [CW-1:0] err_count;

  gray_codec_pipe #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .SYS_CLK   (SYS_CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data),
    .out_adj   (out_adj),
    .clr_err   (clr_err),
    .err_count (err_count)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic         m;
    logic [W-1:0] d;
    logic         a;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           n_cons = 0;
  int           bp = 0;
  bit           chk_lat = 1'b0;
  bit           hv = 1'b0;
  logic [W-1:0] last_gw = '0;
  int           merr = 0;
  logic [W-1:0] last_data = '0;
  logic         last_mode = 1'b0;
  logic         last_adj = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_enc(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse found by search over all codes rather than by bitwise recurrence.
  function automatic logic [W-1:0] m_dec(input logic [W-1:0] g);
    for (int v = 0; v < (1 << W); v++) begin
      if (m_enc(W'(v)) == g) return W'(v);
    end
    return '0;
  endfunction

  // Downstream ready pattern: 0 always ready, 1 random, 2 stalled.
  always @(posedge SYS_CLK) begin
    #1;
    case (bp)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: model accepts at input, compare at output (sampled mid-cycle).
  always @(negedge SYS_CLK) begin
    exp_t         e;
    logic [W-1:0] gw;
    if (reset) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("data", 32'(out_data), 32'(e.d));
          chk("mode", 32'(out_mode), 32'(e.m));
          chk("adj", 32'(out_adj), 32'(e.a));
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
          last_data = out_data;
          last_mode = out_mode;
          last_adj  = out_adj;
          n_cons++;
        end
      end
      if (in_valid && in_ready) begin
        e.m   = in_mode;
        e.d   = in_mode ? m_dec(in_data) : m_enc(in_data);
        gw    = in_mode ? in_data : e.d;
        e.a   = hv && ($countones(gw ^ last_gw) > 1);
        e.cyc = cyc;
        if (e.a && merr < (1 << CW) - 1) merr++;
        last_gw = gw;
        hv      = 1'b1;
        q.push_back(e);
      end
    end
    cyc++;
  end

  // All driver tasks start and end at posedge+1.
  task automatic send(input logic m, input logic [W-1:0] d);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    n = 0;
    do begin
      @(negedge SYS_CLK);
      ok = in_ready;
      @(posedge SYS_CLK);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge SYS_CLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge SYS_CLK);
      n++;
    end
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic clr();
    clr_err = 1'b1;
    @(posedge SYS_CLK);
    #1;
    clr_err = 1'b0;
    hv   = 1'b0;
    merr = 0;
    chk("clr_err_count", 32'(err_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b;
    logic [W-1:0] g;
    int           base;

    reset = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; clr_err = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_out_adj", 32'(out_adj), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge SYS_CLK);
    #3 reset = 1'b1;
    idle(1);

    // Encode sweep, full throughput, fixed latency.
    chk_lat = 1'b1;
    for (int v = 0; v < 16; v++) send(1'b0, W'(v));
    drain();
    chk_lat = 1'b0;
    chk("enc_sweep_err", 32'(err_count), 32'd0);

    // Decode examples and random round trips under random backpressure.
    send(1'b1, 4'b1111);
    drain();
    chk("dec_1111", 32'(last_data), 32'b1010);
    chk("dec_mode", 32'(last_mode), 32'd1);
    send(1'b1, 4'b1000);
    drain();
    chk("dec_1000", 32'(last_data), 32'b1111);
    bp = 1;
    repeat (8) begin
      b = W'($urandom);
      send(1'b0, b);
      drain();
      g = last_data;
      send(1'b1, g);
      drain();
      chk("roundtrip", 32'(last_data), 32'(b));
    end
    chk("rt_err_count", 32'(err_count), 32'(merr));

    // Adjacency violation, then clear re-seeds history.
    bp = 0;
    clr();
    send(1'b1, 4'b0000);
    send(1'b1, 4'b0001);
    send(1'b1, 4'b0111);
    drain();
    chk("adj_third", 32'(last_adj), 32'd1);
    chk("adj_err_count", 32'(err_count), 32'd1);
    clr();
    send(1'b1, 4'b1111);
    drain();
    chk("adj_after_clr", 32'(last_adj), 32'd0);

    // Backpressure: two accepted then stall, all four emerge in order.
    clr();
    bp = 2;
    idle(1);
    base = n_cons;
    fork
      begin
        send(1'b0, 4'd5);
        send(1'b0, 4'd6);
        send(1'b0, 4'd7);
        send(1'b0, 4'd8);
      end
      begin
        repeat (3) @(negedge SYS_CLK);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        bp = 0;
      end
    join
    drain();
    chk("bp_count", 32'(n_cons - base), 32'd4);

    // Saturation: seed plus five violating words.
    clr();
    for (int i = 0; i < 6; i++) send(1'b1, (i % 2) ? 4'b0011 : 4'b0000);
    drain();
    chk("sat_err_count", 32'(err_count), 32'd3);

    // Reset with both stages full.
    bp = 2;
    idle(1);
    send(1'b1, 4'b0000);
    send(1'b1, 4'b0000);
    #2 reset = 1'b0;
    q.delete();
    hv   = 1'b0;
    merr = 0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_err_count", 32'(err_count), 32'd0);
    @(posedge SYS_CLK);
    #3 reset = 1'b1;
    bp = 0;
    idle(1);
    send(1'b1, 4'b1111);
    drain();
    chk("rst_first_adj", 32'(last_adj), 32'd0);
    chk("rst_first_err", 32'(err_count), 32'd0);

    // Random mixed traffic with random backpressure.
    bp = 1;
    clr();
    repeat (150) begin
      if ($urandom_range(0, 19) == 0) begin
        drain();
        clr();
      end
      send(1'($urandom_range(0, 1)), W'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    chk("rand_err_count", 32'(err_count), 32'(merr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
